// File: rtl/sha_dispatch_if.sv
// rtl/sha_dispatch_if.sv - host/core-bank handshake bundle for the SHA job dispatcher
//
// Purpose: groups the job request, abort, core control, core result and host
// result signals of sha_dispatch into one interface.
// Modports:
//   master - host/core-bank side: drives job_*, abort, core_out_*, res_ready
//   slave  - dispatcher side: drives job_ready, core_rst/valid/nonce_base,
//            res_*, busy, round_cnt (and stat_cycles with SHA_DISPATCH_STATS_EN)
// Optional: SHA_DISPATCH_STATS_EN adds stat_cycles.

interface sha_dispatch_if #(
  parameter int NUM_CORES = 4
);
  logic                      job_valid;
  logic                      job_ready;
  logic [31:0]               job_nonce_base;
  logic                      abort;
  logic [NUM_CORES-1:0]      core_rst;
  logic [NUM_CORES-1:0]      core_valid;
  logic [NUM_CORES*32-1:0]   core_nonce_base;
  logic [NUM_CORES-1:0]      core_out_valid;
  logic [NUM_CORES*32-1:0]   core_out_nonce;
  logic                      res_valid;
  logic                      res_ready;
  logic                      res_found;
  logic [31:0]               res_nonce;
  logic                      busy;
  logic [15:0]               round_cnt;
`ifdef SHA_DISPATCH_STATS_EN
  logic [31:0]               stat_cycles;
`endif

  modport master (
    output job_valid, job_nonce_base, abort, core_out_valid, core_out_nonce, res_ready,
    input  job_ready, core_rst, core_valid, core_nonce_base, res_valid, res_found,
           res_nonce, busy, round_cnt
`ifdef SHA_DISPATCH_STATS_EN
    , input stat_cycles
`endif
  );

  modport slave (
    input  job_valid, job_nonce_base, abort, core_out_valid, core_out_nonce, res_ready,
    output job_ready, core_rst, core_valid, core_nonce_base, res_valid, res_found,
           res_nonce, busy, round_cnt
`ifdef SHA_DISPATCH_STATS_EN
    , output stat_cycles
`endif
  );
endinterface

// File: rtl/sha_dispatch.sv
// rtl/sha_dispatch.sv - nonce-slice job scheduler and result arbiter for a sha256_double bank
//
// Purpose: splits one nonce search job into NUM_CORES slices of 2**SLICE_LOG2,
// sequences core reset / start / timeout rounds, and returns the first winning
// nonce (or not-found after MAX_ROUNDS) to the host.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   bus       - sha_dispatch_if.slave: job request/abort in, core control out,
//               core results in, host result out, busy/round_cnt status
// Optional: SHA_DISPATCH_STATS_EN adds bus.stat_cycles (RUN cycles since accept).

module sha_dispatch #(
  parameter int NUM_CORES    = 4,
  parameter int SLICE_LOG2   = 20,
  parameter int ROUND_CYCLES = 1100000,
  parameter int RST_CYCLES   = 2,
  parameter int MAX_ROUNDS   = 16
) (
  input  logic           clk,
  input  logic           rst,
  sha_dispatch_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    RST_CORES,
    DISPATCH,
    RUN,
    REPORT
  } state_t;

  localparam int TW = $clog2(ROUND_CYCLES);
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST   = TW'(ROUND_CYCLES - 1);
  localparam logic [RW-1:0] RST_LAST     = RW'(RST_CYCLES - 1);
  localparam logic [31:0]   ROUND_STEP   = 32'(NUM_CORES) << SLICE_LOG2;
  localparam logic [15:0]   ROUNDS_LIMIT = 16'(MAX_ROUNDS);

  state_t                    state;
  logic [31:0]               base;
  logic [TW-1:0]             timer;
  logic [RW-1:0]             rst_cnt;
  logic [15:0]               round_cnt_q;
  logic [NUM_CORES-1:0]      core_rst_q;
  logic [NUM_CORES-1:0]      core_valid_q;
  logic [NUM_CORES*32-1:0]   core_base_q;
  logic                      res_valid_q;
  logic                      res_found_q;
  logic [31:0]               res_nonce_q;
  logic                      busy_q;
  logic                      job_ready_q;
`ifdef SHA_DISPATCH_STATS_EN
  logic [31:0]               stat_q;
`endif

  // Lowest-index core wins: scan from the top so the lowest set bit writes last.
  logic        hit;
  logic [31:0] hit_nonce;
  always_comb begin
    hit_nonce = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (bus.core_out_valid[i]) hit_nonce = bus.core_out_nonce[32*i +: 32];
    end
  end
  assign hit = |bus.core_out_valid;

  // round_cnt saturates rather than wrapping.
  logic [15:0] round_next;
  assign round_next = (round_cnt_q == 16'hFFFF) ? round_cnt_q : round_cnt_q + 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      base         <= '0;
      timer        <= '0;
      rst_cnt      <= '0;
      round_cnt_q  <= '0;
      core_rst_q   <= '1;
      core_valid_q <= '0;
      core_base_q  <= '0;
      res_valid_q  <= 1'b0;
      res_found_q  <= 1'b0;
      res_nonce_q  <= '0;
      busy_q       <= 1'b0;
      job_ready_q  <= 1'b1;
`ifdef SHA_DISPATCH_STATS_EN
      stat_q       <= '0;
`endif
    end else if (bus.abort && state != IDLE) begin
      // Cancel wins over hit, timeout and result handshake; round_cnt is kept.
      state        <= IDLE;
      core_rst_q   <= '1;
      core_valid_q <= '0;
      res_valid_q  <= 1'b0;
      res_found_q  <= 1'b0;
      res_nonce_q  <= '0;
      busy_q       <= 1'b0;
      job_ready_q  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.job_valid && job_ready_q) begin
            base        <= bus.job_nonce_base;
            round_cnt_q <= '0;
            rst_cnt     <= '0;
            busy_q      <= 1'b1;
            job_ready_q <= 1'b0;
            state       <= RST_CORES;
`ifdef SHA_DISPATCH_STATS_EN
            stat_q      <= '0;
`endif
          end
        end

        RST_CORES: begin
          if (rst_cnt == RST_LAST) begin
            state        <= DISPATCH;
            core_rst_q   <= '0;
            core_valid_q <= '1;
            for (int i = 0; i < NUM_CORES; i++) begin
              core_base_q[32*i +: 32] <= base + (32'(i) << SLICE_LOG2);
            end
          end else begin
            rst_cnt <= rst_cnt + RW'(1);
          end
        end

        DISPATCH: begin
          core_valid_q <= '0;
          timer        <= '0;
          state        <= RUN;
        end

        RUN: begin
          timer <= timer + TW'(1);
`ifdef SHA_DISPATCH_STATS_EN
          stat_q <= stat_q + 32'd1;
`endif
          if (hit) begin
            res_nonce_q <= hit_nonce;
            res_found_q <= 1'b1;
            res_valid_q <= 1'b1;
            core_rst_q  <= '1;
            state       <= REPORT;
          end else if (timer == TIMER_LAST) begin
            round_cnt_q <= round_next;
            base        <= base + ROUND_STEP;
            core_rst_q  <= '1;
            if (round_next == ROUNDS_LIMIT) begin
              res_found_q <= 1'b0;
              res_nonce_q <= '0;
              res_valid_q <= 1'b1;
              state       <= REPORT;
            end else begin
              rst_cnt <= '0;
              state   <= RST_CORES;
            end
          end
        end

        REPORT: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            job_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.job_ready       = job_ready_q;
  assign bus.core_rst        = core_rst_q;
  assign bus.core_valid      = core_valid_q;
  assign bus.core_nonce_base = core_base_q;
  assign bus.res_valid       = res_valid_q;
  assign bus.res_found       = res_found_q;
  assign bus.res_nonce       = res_nonce_q;
  assign bus.busy            = busy_q;
  assign bus.round_cnt       = round_cnt_q;
`ifdef SHA_DISPATCH_STATS_EN
  assign bus.stat_cycles     = stat_q;
`endif

endmodule

// File: tb/tb_sha_dispatch.sv
// tb/tb_sha_dispatch.sv - self-checking bench for sha_dispatch

module tb_sha_dispatch;
  localparam int NUM_CORES    = 4;
  localparam int SLICE_LOG2   = 4;
  localparam int ROUND_CYCLES = 8;
  localparam int RST_CYCLES   = 2;
  localparam int MAX_ROUNDS   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sha_dispatch_if #(.NUM_CORES(NUM_CORES)) bus ();

  sha_dispatch #(
    .NUM_CORES   (NUM_CORES),
    .SLICE_LOG2  (SLICE_LOG2),
    .ROUND_CYCLES(ROUND_CYCLES),
    .RST_CYCLES  (RST_CYCLES),
    .MAX_ROUNDS  (MAX_ROUNDS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Job model: t counts cycles since the current round began (0 = first
  // core-reset cycle). t == RST_CYCLES is the start pulse; the following
  // ROUND_CYCLES cycles are the search window.
  typedef struct {
    logic        active;
    logic        report;
    logic        found;
    int          t;
    logic [15:0] round;
    logic [31:0] base;
    logic [31:0] nonce;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_next(input mstate_t s);
    mstate_t n = s;
    if ((s.active || s.report) && bus.abort) begin
      n.active = 1'b0;
      n.report = 1'b0;
    end else if (s.active) begin
      if (s.t > RST_CYCLES && bus.core_out_valid != '0) begin
        for (int i = 0; i < NUM_CORES; i++) begin
          if (bus.core_out_valid[i] && n.active) begin
            n.nonce  = bus.core_out_nonce[32*i +: 32];
            n.active = 1'b0;
          end
        end
        n.report = 1'b1;
        n.found  = 1'b1;
      end else if (s.t == RST_CYCLES + ROUND_CYCLES) begin
        if (s.round != 16'hFFFF) n.round = s.round + 1;
        n.base = s.base + NUM_CORES * (1 << SLICE_LOG2);
        if (n.round == MAX_ROUNDS) begin
          n.active = 1'b0;
          n.report = 1'b1;
          n.found  = 1'b0;
          n.nonce  = 0;
        end else begin
          n.t = 0;
        end
      end else begin
        n.t = s.t + 1;
      end
    end else if (s.report) begin
      if (bus.res_ready) n.report = 1'b0;
    end else if (bus.job_valid) begin
      n.active = 1'b1;
      n.t      = 0;
      n.base   = bus.job_nonce_base;
      n.round  = 0;
    end
    return n;
  endfunction

  function automatic logic [127:0] exp_bases(input logic [31:0] b);
    logic [127:0] v;
    for (int i = 0; i < NUM_CORES; i++) v[32*i +: 32] = b + i * (1 << SLICE_LOG2);
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '{default: 0};
    else     m <= model_next(m);
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("cmp_job_ready", bus.job_ready, !m.active && !m.report);
      chk("cmp_busy", bus.busy, m.active || m.report);
      chk("cmp_core_rst", bus.core_rst, (m.active && m.t >= RST_CYCLES) ? 4'h0 : 4'hF);
      chk("cmp_core_valid", bus.core_valid, (m.active && m.t == RST_CYCLES) ? 4'hF : 4'h0);
      chk("cmp_round_cnt", bus.round_cnt, m.round);
      chk("cmp_res_valid", bus.res_valid, m.report);
      if (m.active && m.t == RST_CYCLES)
        chk("cmp_core_bases", bus.core_nonce_base, exp_bases(m.base));
      if (m.report) begin
        chk("cmp_res_found", bus.res_found, m.found);
        chk("cmp_res_nonce", bus.res_nonce, m.nonce);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start_job(input logic [31:0] b);
    bus.job_valid      = 1'b1;
    bus.job_nonce_base = b;
    step();
    bus.job_valid      = 1'b0;
  endtask

  task automatic wait_dispatch(output logic [127:0] bases);
    int n = 0;
    while (bus.core_valid !== 4'hF && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) chk("dispatch_timeout", 1'b0, 1'b1);
    bases = bus.core_nonce_base;
  endtask

  task automatic wait_res();
    int n = 0;
    while (bus.res_valid !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) chk("result_timeout", 1'b0, 1'b1);
  endtask

  // Called in the start-pulse cycle; drives the hit on search cycle k and
  // returns in the cycle after it.
  task automatic hit_at(input int k, input logic [3:0] v, input logic [127:0] n);
    repeat (k + 1) step();
    bus.core_out_valid = v;
    bus.core_out_nonce = n;
    step();
    bus.core_out_valid = '0;
    bus.core_out_nonce = '0;
  endtask

  task automatic handshake();
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
  endtask

  logic [127:0] b;

  initial begin
    bus.job_valid      = 1'b0;
    bus.job_nonce_base = '0;
    bus.abort          = 1'b0;
    bus.core_out_valid = '0;
    bus.core_out_nonce = '0;
    bus.res_ready      = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_job_ready", bus.job_ready, 1'b1);
    chk("rst_core_rst", bus.core_rst, 4'hF);
    chk("rst_core_valid", bus.core_valid, 4'h0);
    chk("rst_core_bases", bus.core_nonce_base, 128'h0);
    chk("rst_res_valid", bus.res_valid, 1'b0);
    chk("rst_res_found", bus.res_found, 1'b0);
    chk("rst_res_nonce", bus.res_nonce, 32'h0);
    chk("rst_round_cnt", bus.round_cnt, 16'h0);
    chk("rst_busy", bus.busy, 1'b0);
    rst = 1'b0;
    step();

    // 1: accept, two reset cycles, one start pulse with slice bases
    start_job(32'h100);
    chk("t1_job_ready", bus.job_ready, 1'b0);
    chk("t1_busy", bus.busy, 1'b1);
    chk("t1_rst_c1", bus.core_rst, 4'hF);
    step();
    chk("t1_rst_c2", bus.core_rst, 4'hF);
    chk("t1_no_pulse", bus.core_valid, 4'h0);
    step();
    chk("t1_pulse", bus.core_valid, 4'hF);
    chk("t1_rst_low", bus.core_rst, 4'h0);
    chk("t1_bases", bus.core_nonce_base, 128'h00000130_00000120_00000110_00000100);

    // 2: hit on core 2, result held while res_ready low
    hit_at(3, 4'b0100, {32'h0, 32'h125, 32'h0, 32'h0});
`ifdef SHA_DISPATCH_STATS_EN
    chk("t2_stat_cycles", bus.stat_cycles, 32'd4);
`endif
    for (int i = 0; i < 5; i++) begin
      chk("t2_res_valid", bus.res_valid, 1'b1);
      chk("t2_res_found", bus.res_found, 1'b1);
      chk("t2_res_nonce", bus.res_nonce, 32'h125);
      step();
    end
    handshake();
    chk("t2_released", bus.res_valid, 1'b0);
    chk("t2_job_ready", bus.job_ready, 1'b1);

    // 3: simultaneous hits -> lowest index; hit on last search cycle wins over timeout
    start_job(32'h100);
    wait_dispatch(b);
    hit_at(2, 4'b1010, {32'h131, 32'h0, 32'h111, 32'h0});
    chk("t3_lowest", bus.res_nonce, 32'h111);
    handshake();
    start_job(32'h100);
    wait_dispatch(b);
    hit_at(7, 4'b0001, {32'h0, 32'h0, 32'h0, 32'h107});
    chk("t3_last_found", bus.res_found, 1'b1);
    chk("t3_last_nonce", bus.res_nonce, 32'h107);
    chk("t3_last_round", bus.round_cnt, 16'h0);
    handshake();

    // 4: exhaustion after three rounds
    start_job(32'h100);
    wait_dispatch(b);
    chk("t4_round0", b[31:0], 32'h100);
    step();
    wait_dispatch(b);
    chk("t4_round1", b[31:0], 32'h140);
    step();
    wait_dispatch(b);
    chk("t4_round2", b[31:0], 32'h180);
    step();
    wait_res();
    chk("t4_found", bus.res_found, 1'b0);
    chk("t4_nonce", bus.res_nonce, 32'h0);
    chk("t4_rounds", bus.round_cnt, 16'd3);
    handshake();

    // 5: base wrap-around
    start_job(32'hFFFFFFF0);
    wait_dispatch(b);
    chk("t5_bases", b, 128'h00000020_00000010_00000000_FFFFFFF0);
    step();
    wait_dispatch(b);
    chk("t5_next_round", b[31:0], 32'h00000030);

    // 6a: abort on search cycle 4
    repeat (5) step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("t6_abort_rst", bus.core_rst, 4'hF);
    chk("t6_abort_ready", bus.job_ready, 1'b1);
    chk("t6_abort_res", bus.res_valid, 1'b0);
    chk("t6_abort_round", bus.round_cnt, 16'd1);
    repeat (3) step();
    chk("t6_abort_quiet", bus.res_valid, 1'b0);

    // 6b: abort together with res_ready in REPORT
    start_job(32'h200);
    wait_dispatch(b);
    hit_at(1, 4'b0001, {32'h0, 32'h0, 32'h0, 32'h201});
    chk("t6_report", bus.res_valid, 1'b1);
    bus.abort     = 1'b1;
    bus.res_ready = 1'b1;
    step();
    bus.abort     = 1'b0;
    bus.res_ready = 1'b0;
    chk("t6_ab_res", bus.res_valid, 1'b0);
    chk("t6_ab_idle", bus.job_ready, 1'b1);
    chk("t6_ab_busy", bus.busy, 1'b0);

    // 6c: asynchronous reset mid-search, checked before any clock edge
    start_job(32'h300);
    wait_dispatch(b);
    repeat (3) step();
    chk("t6_pre_rst", bus.core_rst, 4'h0);
    rst = 1'b1;
    #1;
    chk("t6_arst_core_rst", bus.core_rst, 4'hF);
    chk("t6_arst_busy", bus.busy, 1'b0);
    chk("t6_arst_ready", bus.job_ready, 1'b1);
    chk("t6_arst_valid", bus.core_valid, 4'h0);
    chk("t6_arst_bases", bus.core_nonce_base, 128'h0);
    chk("t6_arst_res", bus.res_valid, 1'b0);
    step();
    rst = 1'b0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/sha_dispatch.md
Name: sha_dispatch

Overview:
- Job scheduler for a bank of NUM_CORES sha256_double cores; splits one nonce search job into per-core slices and sequences core reset, start and timeout rounds.
- Collects the first winning nonce and returns a single result to the host-side controller (UART front end).
- Block data, midstate and target go straight to the cores; this block owns only nonce allocation, core control and result arbitration.

Parameters:
- NUM_CORES, 4, number of sha256_double instances driven; must be 1 to 16.
- SLICE_LOG2, 20, per-core nonce slice size is 2**SLICE_LOG2.
- ROUND_CYCLES, 1100000, RUN cycles per round before the round is declared exhausted; must be 2 or more.
- RST_CYCLES, 2, cycles core_rst is held before each dispatch; must be 1 or more.
- MAX_ROUNDS, 16, rounds before reporting not-found; must be 1 to 65535.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- job_valid  in  1  job request
- job_ready  out  1  high only in IDLE
- job_nonce_base  in  32  first nonce of the job
- abort  in  1  synchronous job cancel
- core_rst  out  NUM_CORES  per-core reset, all bits equal
- core_valid  out  NUM_CORES  one-cycle start pulse, all bits equal
- core_nonce_base  out  NUM_CORES*32  core i in bits [32*i +: 32]
- core_out_valid  in  NUM_CORES  core i found a nonce, one-cycle pulse or level
- core_out_nonce  in  NUM_CORES*32  winning nonce of core i
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_found  out  1  1 = nonce found, 0 = exhausted
- res_nonce  out  32  winning nonce, 0 when not found
- busy  out  1  state != IDLE
- round_cnt  out  16  rounds completed in current job

Behaviour:
- Reset: async, active-high. Outputs on reset:
  - state IDLE
  - core_rst all 1
  - core_valid 0, core_nonce_base 0
  - res_valid 0, res_found 0, res_nonce 0
  - round_cnt 0, busy 0, job_ready 1
- States: IDLE, RST_CORES, DISPATCH, RUN, REPORT. core_rst is high in IDLE, RST_CORES and REPORT, low in DISPATCH and RUN.
- IDLE:
  - On job_valid && job_ready: latch job_nonce_base into base, round_cnt=0, go to RST_CORES.
- RST_CORES:
  - Hold for exactly RST_CYCLES cycles, then go to DISPATCH.
- DISPATCH (one cycle):
  - core_valid = all 1.
  - core_nonce_base[i] = base + i*2**SLICE_LOG2, mod 2**32.
  - Next state RUN, timer=0.
- RUN:
  - core_valid = 0; timer increments every cycle.
  - Any core_out_valid bit set: lowest index wins; latch its core_out_nonce into res_nonce, set res_found=1, go to REPORT.
  - Else, timer == ROUND_CYCLES-1:
    - round_cnt += 1; base += NUM_CORES*2**SLICE_LOG2, mod 2**32.
    - If the new round_cnt == MAX_ROUNDS: res_found=0, res_nonce=0, go to REPORT.
    - Otherwise go to RST_CORES.
  - A hit on the timeout cycle takes precedence over the timeout.
- REPORT:
  - res_valid=1; res_found and res_nonce held stable until res_ready.
  - On res_valid && res_ready: res_valid=0 next cycle, go to IDLE.
- abort (any state except IDLE):
  - Next state IDLE, res_valid=0 and core_valid=0 next cycle, round_cnt holds its value.
  - A pending result is discarded. abort is ignored in IDLE.
  - abort has priority over hit, timeout and the res_ready handshake in the same cycle.
- Latency: job accept to core_valid pulse is RST_CYCLES+1 cycles. core_out_valid to res_valid is 1 cycle.
- round_cnt saturates at 65535.

Optional Feature:
- Macro: SHA_DISPATCH_STATS_EN.
- Defined: adds output stat_cycles (32 bits) counting cycles spent in RUN since the last job accept; cleared on accept, frozen in REPORT and IDLE, wraps mod 2**32, reset to 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
(all with NUM_CORES=4, SLICE_LOG2=4, ROUND_CYCLES=8, RST_CYCLES=2, MAX_ROUNDS=3)
1. Job base 0x100 -> core_rst high 2 cycles, then one core_valid pulse with core bases 0x100, 0x110, 0x120, 0x130; job_ready=0 and busy=1 from the cycle after accept.
2. core_out_valid[2] with nonce 0x125 on RUN cycle 3, res_ready=0 for 5 cycles -> res_valid=1, res_found=1, res_nonce=0x125, all held stable; released one cycle after res_ready=1; job_ready=1 after.
3. core_out_valid[1] (0x111) and core_out_valid[3] (0x131) in the same cycle -> res_nonce=0x111. Hit on timer=7 -> found=1, not a new round.
4. No hits -> three dispatches with first-core base 0x100, 0x140, 0x180; then res_found=0, res_nonce=0, round_cnt=3.
5. Job base 0xFFFFFFF0 -> core bases 0xFFFFFFF0, 0x00000000, 0x00000010, 0x00000020; next round first-core base 0x00000030.
6. abort in RUN cycle 4 -> IDLE next cycle, core_rst high, no res_valid pulse. abort coincident with res_ready in REPORT -> no completion, IDLE. rst asserted mid-RUN -> immediate reset values without waiting for a clock edge.
